// File: rtl/input_event_unit.sv
// Front-end command stage: turns held scan codes and changing voice codes into
// single-cycle game actions, serialized through a FIFO with a minimum pulse gap.
module input_event_unit #(
    parameter int STABLE_CYC = 2,
    parameter int GAP_CYC    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_char,
    input  logic [7:0] i_vocal,
    output logic       o_left,
    output logic       o_right,
    output logic       o_select,
    output logic       o_start,
    output logic       o_uno,
    output logic       o_replay,
    output logic       o_busy,
    output logic [7:0] o_drop_cnt
);
    localparam int PW = $clog2(FIFO_DEPTH);
    typedef logic [PW-1:0] ptr_t;
    typedef logic [PW:0]   cnt_t;

    localparam logic [3:0] STABLE_LAST = 4'(STABLE_CYC - 1);
    localparam logic [7:0] GAP_LOAD    = 8'(GAP_CYC);
    localparam cnt_t       DEPTH_CNT   = cnt_t'(FIFO_DEPTH);

    function automatic logic [2:0] key_map(input logic [7:0] code);
        case (code)
            8'h15:   key_map = 3'd1;
            8'h24:   key_map = 3'd2;
            8'h5A:   key_map = 3'd3;
            8'h29:   key_map = 3'd4;
            8'h3C:   key_map = 3'd5;
            8'h2D:   key_map = 3'd6;
            default: key_map = 3'd0;
        endcase
    endfunction

    function automatic logic [2:0] voice_map(input logic [7:0] code);
        case (code)
            8'd1:    voice_map = 3'd1;
            8'd2:    voice_map = 3'd2;
            8'd3:    voice_map = 3'd3;
            8'd4:    voice_map = 3'd4;
            8'd5:    voice_map = 3'd6;
            8'd6:    voice_map = 3'd5;
            default: voice_map = 3'd0;
        endcase
    endfunction

    logic [7:0] last_char_r, last_vocal_r, fired_char_r, gap_r;
    logic [3:0] stable_r;
    logic       armed_r, pend_valid_r;
    logic [2:0] pend_code_r;
    logic [2:0] mem_r [FIFO_DEPTH];
    ptr_t       wr_ptr_r, rd_ptr_r;
    cnt_t       count_r;

    logic [2:0] kb_code_s, v_code_s, wr_code_s, pop_code_s;
    logic [3:0] stable_nxt_s;
    logic       armed_s, kb_req_s, v_req_s, pop_s, wr_req_s, wr_ok_s, ovw_s;
    logic       pend_valid_nxt_s;
    logic [1:0] drop_inc_s;
    logic [8:0] drop_sum_s;
    logic [7:0] drop_nxt_s, gap_nxt_s;
    cnt_t       count_nxt_s;

    // Detection, write arbitration and next-state computation.
    always_comb begin
        kb_code_s  = key_map(i_char);
        v_code_s   = voice_map(i_vocal);
        pop_code_s = mem_r[rd_ptr_r];
        if ((i_char == last_char_r) && (kb_code_s != 3'd0)) begin
            if (stable_r == 4'hF) begin
                stable_nxt_s = stable_r;
            end else begin
                stable_nxt_s = stable_r + 4'd1;
            end
        end else begin
            stable_nxt_s = 4'd0;
        end
        // Re-arm as soon as the input leaves the code that last fired.
        armed_s  = armed_r || (i_char != fired_char_r);
        kb_req_s = armed_s && (kb_code_s != 3'd0) && (stable_nxt_s == STABLE_LAST);
        v_req_s  = (i_vocal != last_vocal_r) && (v_code_s != 3'd0);

        pop_s     = (count_r != cnt_t'(0)) && (gap_r == 8'd0);
        wr_req_s  = kb_req_s || pend_valid_r;
        wr_code_s = kb_req_s ? kb_code_s : pend_code_r;
        wr_ok_s   = wr_req_s && ((count_r != DEPTH_CNT) || pop_s);
        ovw_s     = v_req_s && pend_valid_r && kb_req_s;

        if (v_req_s) begin
            pend_valid_nxt_s = 1'b1;
        end else if (pend_valid_r && !kb_req_s) begin
            pend_valid_nxt_s = 1'b0;
        end else begin
            pend_valid_nxt_s = pend_valid_r;
        end

        drop_inc_s = {1'b0, (wr_req_s && !wr_ok_s)} + {1'b0, ovw_s};
        drop_sum_s = {1'b0, o_drop_cnt} + {7'd0, drop_inc_s};
        if (drop_sum_s[8]) begin
            drop_nxt_s = 8'hFF;
        end else begin
            drop_nxt_s = drop_sum_s[7:0];
        end

        count_nxt_s = count_r + cnt_t'(wr_ok_s) - cnt_t'(pop_s);
        if (pop_s) begin
            gap_nxt_s = GAP_LOAD;
        end else if (gap_r != 8'd0) begin
            gap_nxt_s = gap_r - 8'd1;
        end else begin
            gap_nxt_s = 8'd0;
        end
    end

    // Keyboard and voice detector state plus the voice pending slot.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            last_char_r  <= 8'h00;
            last_vocal_r <= 8'h00;
            fired_char_r <= 8'h00;
            stable_r     <= 4'd0;
            armed_r      <= 1'b1;
            pend_valid_r <= 1'b0;
            pend_code_r  <= 3'd0;
        end else begin
            last_char_r  <= i_char;
            last_vocal_r <= i_vocal;
            stable_r     <= stable_nxt_s;
            if (kb_req_s) begin
                armed_r      <= 1'b0;
                fired_char_r <= i_char;
            end else begin
                armed_r <= armed_s;
            end
            pend_valid_r <= pend_valid_nxt_s;
            if (v_req_s) begin
                pend_code_r <= v_code_s;
            end
        end
    end

    // Event FIFO, gap timer, drop counter and registered action outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 3'd0;
            end
            wr_ptr_r   <= ptr_t'(0);
            rd_ptr_r   <= ptr_t'(0);
            count_r    <= cnt_t'(0);
            gap_r      <= 8'd0;
            o_drop_cnt <= 8'd0;
            o_busy     <= 1'b0;
            o_left     <= 1'b0;
            o_right    <= 1'b0;
            o_select   <= 1'b0;
            o_start    <= 1'b0;
            o_uno      <= 1'b0;
            o_replay   <= 1'b0;
        end else begin
            if (wr_ok_s) begin
                mem_r[wr_ptr_r] <= wr_code_s;
                wr_ptr_r        <= wr_ptr_r + ptr_t'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + ptr_t'(1'b1);
            end
            count_r    <= count_nxt_s;
            gap_r      <= gap_nxt_s;
            o_drop_cnt <= drop_nxt_s;
            o_busy     <= (count_nxt_s != cnt_t'(0)) || pend_valid_nxt_s || (gap_nxt_s != 8'd0);
            o_left     <= pop_s && (pop_code_s == 3'd1);
            o_right    <= pop_s && (pop_code_s == 3'd2);
            o_select   <= pop_s && (pop_code_s == 3'd3);
            o_start    <= pop_s && (pop_code_s == 3'd4);
            o_uno      <= pop_s && (pop_code_s == 3'd5);
            o_replay   <= pop_s && (pop_code_s == 3'd6);
        end
    end

endmodule

// File: tb/tb_input_event_unit.sv
// Directed bench for input_event_unit: a default instance and a GAP_CYC=255
// instance share stimulus; each scenario task checks its own expectations.
module tb_input_event_unit;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] ch, vc;
    logic a_left, a_right, a_select, a_start, a_uno, a_replay, a_busy;
    logic b_left, b_right, b_select, b_start, b_uno, b_replay, b_busy;
    logic [7:0] a_drop, b_drop;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int a_code_q[$], a_cyc_q[$], b_code_q[$], b_cyc_q[$];
    logic [7:0] keys [7] = '{8'h15, 8'h24, 8'h5A, 8'h29, 8'h3C, 8'h2D, 8'h15};

    input_event_unit dut_a (
        .i_clk(clk), .i_rst(rst), .i_char(ch), .i_vocal(vc),
        .o_left(a_left), .o_right(a_right), .o_select(a_select), .o_start(a_start),
        .o_uno(a_uno), .o_replay(a_replay), .o_busy(a_busy), .o_drop_cnt(a_drop)
    );

    input_event_unit #(.GAP_CYC(255)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_char(ch), .i_vocal(vc),
        .o_left(b_left), .o_right(b_right), .o_select(b_select), .o_start(b_start),
        .o_uno(b_uno), .o_replay(b_replay), .o_busy(b_busy), .o_drop_cnt(b_drop)
    );

    always #5 clk = ~clk;

    // Encodes the six pulse outputs: 0 none, 1..6 event code, 7 more than one high.
    function automatic int code_of(input logic l, r, s, st, u, rp);
        int n;
        n = int'(l === 1'b1) + int'(r === 1'b1) + int'(s === 1'b1)
          + int'(st === 1'b1) + int'(u === 1'b1) + int'(rp === 1'b1);
        if (n > 1) return 7;
        if (l === 1'b1) return 1;
        if (r === 1'b1) return 2;
        if (s === 1'b1) return 3;
        if (st === 1'b1) return 4;
        if (u === 1'b1) return 5;
        if (rp === 1'b1) return 6;
        return 0;
    endfunction

    task automatic tick(input int n);
        int ca, cb;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            ca = code_of(a_left, a_right, a_select, a_start, a_uno, a_replay);
            cb = code_of(b_left, b_right, b_select, b_start, b_uno, b_replay);
            if (ca != 0) begin a_code_q.push_back(ca); a_cyc_q.push_back(cyc); end
            if (cb != 0) begin b_code_q.push_back(cb); b_cyc_q.push_back(cyc); end
        end
    endtask

    task automatic clear_logs();
        a_code_q.delete(); a_cyc_q.delete(); b_code_q.delete(); b_cyc_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; ch = 8'h00; vc = 8'h00;
        tick(3);
        n_cmp++;
        if (code_of(a_left, a_right, a_select, a_start, a_uno, a_replay) !== 0) begin
            n_bad++; $display("FAIL reset_a_pulses: got %0d expected 0",
                              code_of(a_left, a_right, a_select, a_start, a_uno, a_replay));
        end
        n_cmp++;
        if (a_busy !== 1'b0 || a_drop !== 8'd0) begin
            n_bad++; $display("FAIL reset_a_busy_drop: got %b/%0d expected 0/0", a_busy, a_drop);
        end
        n_cmp++;
        if (b_busy !== 1'b0 || b_drop !== 8'd0) begin
            n_bad++; $display("FAIL reset_b_busy_drop: got %b/%0d expected 0/0", b_busy, b_drop);
        end
        rst = 1'b0;
        tick(2);
    endtask

    task automatic test_key_hold();
        int base;
        clear_logs();
        base = cyc;
        ch = 8'h15;
        tick(20);
        ch = 8'h00;
        tick(15);
        n_cmp++;
        if (a_code_q.size() !== 1) begin
            n_bad++; $display("FAIL key_hold_count: got %0d pulses expected 1", a_code_q.size());
        end
        if (a_code_q.size() > 0) begin
            n_cmp++;
            if (a_code_q[0] !== 1 || a_cyc_q[0] !== base + 3) begin
                n_bad++; $display("FAIL key_hold_pulse: got code %0d at %0d expected 1 at %0d",
                                  a_code_q[0], a_cyc_q[0] - base, 3);
            end
        end
    endtask

    task automatic test_glitch();
        clear_logs();
        ch = 8'h24;
        tick(1);
        ch = 8'h00;
        tick(10);
        n_cmp++;
        if (a_code_q.size() !== 0 || a_drop !== 8'd0) begin
            n_bad++; $display("FAIL glitch: got %0d pulses drop %0d expected 0/0", a_code_q.size(), a_drop);
        end
    endtask

    task automatic test_voice();
        int base;
        clear_logs();
        base = cyc;
        vc = 8'd2; tick(10);
        vc = 8'd2; tick(10);
        vc = 8'd7; tick(10);
        vc = 8'd3; tick(10);
        n_cmp++;
        if (a_code_q.size() !== 2) begin
            n_bad++; $display("FAIL voice_count: got %0d pulses expected 2", a_code_q.size());
        end
        if (a_code_q.size() >= 2) begin
            n_cmp++;
            if (a_code_q[0] !== 2 || a_cyc_q[0] !== base + 3) begin
                n_bad++; $display("FAIL voice_right: got code %0d at %0d expected 2 at 3",
                                  a_code_q[0], a_cyc_q[0] - base);
            end
            n_cmp++;
            if (a_code_q[1] !== 3 || a_cyc_q[1] !== base + 33) begin
                n_bad++; $display("FAIL voice_select: got code %0d at %0d expected 3 at 33",
                                  a_code_q[1], a_cyc_q[1] - base);
            end
        end
    endtask

    task automatic test_tie();
        int base;
        clear_logs();
        ch = 8'h5A;
        tick(1);
        base = cyc;
        vc = 8'd4;
        tick(12);
        ch = 8'h00;
        vc = 8'd0;
        tick(3);
        n_cmp++;
        if (a_code_q.size() !== 2) begin
            n_bad++; $display("FAIL tie_count: got %0d pulses expected 2", a_code_q.size());
        end
        if (a_code_q.size() >= 2) begin
            n_cmp++;
            if (a_code_q[0] !== 3 || a_cyc_q[0] !== base + 2) begin
                n_bad++; $display("FAIL tie_first: got code %0d at %0d expected 3 at 2",
                                  a_code_q[0], a_cyc_q[0] - base);
            end
            n_cmp++;
            if (a_code_q[1] !== 4 || a_cyc_q[1] - a_cyc_q[0] !== 5) begin
                n_bad++; $display("FAIL tie_second: got code %0d spacing %0d expected 4 spacing 5",
                                  a_code_q[1], a_cyc_q[1] - a_cyc_q[0]);
            end
        end
    endtask

    task automatic test_overflow();
        int base;
        logic busy_hi, busy_lo;
        rst = 1'b1; tick(1); rst = 1'b0; tick(1);
        clear_logs();
        base = cyc;
        for (int i = 0; i < 7; i++) begin
            ch = keys[i];
            tick(2);
        end
        ch = 8'h00;
        busy_hi = 1'b0;
        busy_lo = 1'b1;
        while (cyc - base < 1290) begin
            tick(1);
            if (cyc - base == 1281) busy_hi = b_busy;
            if (cyc - base == 1282) busy_lo = b_busy;
        end
        n_cmp++;
        if (b_code_q.size() !== 5) begin
            n_bad++; $display("FAIL ovf_count: got %0d pulses expected 5", b_code_q.size());
        end
        for (int i = 0; i < b_code_q.size() && i < 5; i++) begin
            n_cmp++;
            if (b_code_q[i] !== i + 1 || b_cyc_q[i] !== base + 3 + 256 * i) begin
                n_bad++; $display("FAIL ovf_pulse%0d: got code %0d at %0d expected %0d at %0d",
                                  i, b_code_q[i], b_cyc_q[i] - base, i + 1, 3 + 256 * i);
            end
        end
        n_cmp++;
        if (b_drop !== 8'd2) begin
            n_bad++; $display("FAIL ovf_drop: got %0d expected 2", b_drop);
        end
        n_cmp++;
        if (busy_hi !== 1'b1 || busy_lo !== 1'b0) begin
            n_bad++; $display("FAIL ovf_busy_fall: got %b%b expected 10", busy_hi, busy_lo);
        end
    endtask

    task automatic test_reset_midop();
        int base;
        int bad_during;
        clear_logs();
        for (int i = 0; i < 4; i++) begin
            ch = keys[i];
            tick(2);
        end
        ch = 8'h3C;
        tick(1);
        rst = 1'b1;
        bad_during = 0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            if (code_of(a_left, a_right, a_select, a_start, a_uno, a_replay) != 0 ||
                code_of(b_left, b_right, b_select, b_start, b_uno, b_replay) != 0 ||
                a_busy !== 1'b0 || b_busy !== 1'b0 || b_drop !== 8'd0) bad_during++;
        end
        n_cmp++;
        if (bad_during !== 0) begin
            n_bad++; $display("FAIL midrst_outputs: got %0d nonzero cycles expected 0", bad_during);
        end
        clear_logs();
        rst = 1'b0;
        base = cyc;
        tick(300);
        n_cmp++;
        if (b_code_q.size() !== 1) begin
            n_bad++; $display("FAIL midrst_b_count: got %0d pulses expected 1", b_code_q.size());
        end
        if (b_code_q.size() > 0) begin
            n_cmp++;
            if (b_code_q[0] !== 5 || b_cyc_q[0] !== base + 3) begin
                n_bad++; $display("FAIL midrst_b_uno: got code %0d at %0d expected 5 at 3",
                                  b_code_q[0], b_cyc_q[0] - base);
            end
        end
        n_cmp++;
        if (a_code_q.size() !== 1 || b_busy !== 1'b0) begin
            n_bad++; $display("FAIL midrst_a_count_b_idle: got %0d pulses busy %b expected 1/0",
                              a_code_q.size(), b_busy);
        end
        ch = 8'h00;
        tick(3);
    endtask

    initial begin
        test_reset();
        test_key_hold();
        test_glitch();
        test_voice();
        test_tie();
        test_overflow();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/input_event_unit.md
Name: input_event_unit

Overview:
- Front-end command stage for the Uno game engine. It sits between the PS/2 scan-code output and the voice-command register on one side, and the Uno FSM action inputs on the other.
- Turns held key codes and changing voice codes into exactly one single-cycle action pulse per user gesture.
- Events are serialized through a small FIFO. Consecutive pulses are spaced by a minimum gap so the game FSM never sees two actions too close together.

Parameters:
- STABLE_CYC, 2: consecutive cycles a mapped scan code must be stable before it counts as a press (range 1..15).
- GAP_CYC, 4: idle cycles forced after each emitted pulse before the next pop (range 0..255).
- FIFO_DEPTH, 4: event FIFO entries; power of 2, at least 2.

Ports:
- i_clk  in  1  system clock (1 MHz game clock domain).
- i_rst  in  1  reset, asynchronous, active-high.
- i_char  in  8  PS/2 scan code; level, held while the key is down, 0x00 when idle.
- i_vocal  in  8  voice command code; level, changes when a new word is recognised.
- o_left  out  1  one-cycle pulse: move selection left.
- o_right  out  1  one-cycle pulse: move selection right.
- o_select  out  1  one-cycle pulse: play card / confirm.
- o_start  out  1  one-cycle pulse: start game.
- o_uno  out  1  one-cycle pulse: call UNO.
- o_replay  out  1  one-cycle pulse: restart game.
- o_busy  out  1  high while the FIFO is non-empty, the voice pending slot is valid, or the gap counter is non-zero.
- o_drop_cnt  out  8  saturating count of events lost to a full FIFO.

Behaviour:
- Reset: clock and reset are i_clk/i_rst; i_rst is asynchronous, active-high. Asserting it clears all of the following:
  - every pulse output, o_busy and o_drop_cnt to 0;
  - FIFO pointers and count to 0, pending slot invalid, gap counter 0;
  - stable counter 0, keyboard armed, registered last char 0x00, registered last vocal 0x00.
- Event codes (3-bit): 1 LEFT, 2 RIGHT, 3 SELECT, 4 START, 5 UNO, 6 REPLAY.
- Keyboard map: 0x15→LEFT, 0x24→RIGHT, 0x5A→SELECT, 0x29→START, 0x3C→UNO, 0x2D→REPLAY. Any other code is unmapped.
- Keyboard detector:
  - A 4-bit stable counter increments while i_char equals its previous-cycle value and is mapped; it resets to 0 on any change.
  - When the counter reaches STABLE_CYC-1 while armed, one push request is issued and the detector disarms.
  - It re-arms only when i_char differs from the code that fired, whether released to 0x00 or changed to another key.
  - A key held forever therefore produces exactly one event.
- Voice map: 1→LEFT, 2→RIGHT, 3→SELECT, 4→START, 5→REPLAY, 6→UNO. Other values are unmapped.
- Voice detector:
  - A request is issued when i_vocal differs from last cycle's registered value and the new value is mapped.
  - A repeated identical code does not fire.
  - A change to an unmapped value updates the register but does not fire.
- Write arbitration (one FIFO write per cycle):
  - A voice request is loaded into a 1-entry pending slot.
  - A keyboard request writes the FIFO directly and has priority.
  - The pending slot writes the FIFO in any cycle with no keyboard write.
  - A new voice request while the slot is still valid overwrites it; the overwritten event increments o_drop_cnt.
- FIFO full:
  - A write attempted when the count equals FIFO_DEPTH is discarded and o_drop_cnt increments.
  - A discarded pending entry is cleared, not retried.
  - o_drop_cnt saturates at 255.
- Pointers wrap modulo FIFO_DEPTH. Simultaneous write and pop on a full FIFO is allowed and accepted, since the pop frees the slot in the same cycle.
- Output stage:
  - When the FIFO is non-empty and the gap counter is 0, pop one entry.
  - Drive the matching output high for exactly one cycle (registered), then load the gap counter with GAP_CYC.
  - The gap counter decrements to 0.
  - At most one pulse output is high in any cycle.
- Latency, empty FIFO and gap 0:
  - Keyboard: pulse high in cycle STABLE_CYC+1 counted from the first edge that samples the new code. With the default that is the 3rd cycle.
  - Voice, uncontended: pulse high 3 cycles after the sampling edge (pending, FIFO, output register).
- Reset mid-operation: all queued and pending events are lost and no pulse is emitted during reset. Because the last-char register resets to 0x00, a key held through reset fires once after release of i_rst.
- Ordering: FIFO order is preserved. In a same-cycle tie the keyboard event precedes the voice event.

Test Plan:
- Hold i_char=0x15 for 20 cycles, then 0x00 → exactly one o_left pulse, in the 3rd cycle after the first sample; no further pulses.
- i_char glitches 0x24 for 1 cycle, then 0x00 → no pulse, o_drop_cnt=0.
- i_vocal 0→2→2→7→3 on successive 10-cycle intervals → o_right, then o_select only; the 7 and the repeated 2 are ignored.
- Same cycle: keyboard 0x5A becomes stable and i_vocal changes to 4 → o_select, then o_start exactly GAP_CYC+1=5 cycles later.
- With GAP_CYC=255, issue 7 distinct key presses rapidly → first 5 accepted (1 popped, 4 queued), o_drop_cnt=2, 5 pulses in order, o_busy falls after the last gap.
- Assert i_rst while 3 events are queued, holding 0x3C through reset → all outputs 0 during reset, queue empty afterwards, exactly one o_uno after release.
